// File: rtl/rv_pkg.sv
// Shared RV32I(M) decode definitions: opcodes, funct7 values, ALU select codes and the ID/EX payload.
// Used by the decode stage, EX stage and ALU; the M extension is enabled with RV_M_EXT_EN.
package rv_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned REG_W   = 5;
   localparam int unsigned SEL_W   = 5;
   localparam int unsigned INSTR_W = 32;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [6:0] F7_ZERO   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [SEL_W-1:0] ALU_ADD    = 5'b00000;
   localparam logic [SEL_W-1:0] ALU_SLL    = 5'b00001;
   localparam logic [SEL_W-1:0] ALU_SLT    = 5'b00010;
   localparam logic [SEL_W-1:0] ALU_SLTU   = 5'b00011;
   localparam logic [SEL_W-1:0] ALU_XOR    = 5'b00100;
   localparam logic [SEL_W-1:0] ALU_SRL    = 5'b00101;
   localparam logic [SEL_W-1:0] ALU_OR     = 5'b00110;
   localparam logic [SEL_W-1:0] ALU_AND    = 5'b00111;
   localparam logic [SEL_W-1:0] ALU_FWD    = 5'b01000;
   localparam logic [SEL_W-1:0] ALU_SUB    = 5'b10000;
   localparam logic [SEL_W-1:0] ALU_SRA    = 5'b10101;
   localparam logic [SEL_W-1:0] ALU_MUL    = 5'b11000;
   localparam logic [SEL_W-1:0] ALU_MULH   = 5'b11001;
   localparam logic [SEL_W-1:0] ALU_MULHSU = 5'b11010;
   localparam logic [SEL_W-1:0] ALU_MULHU  = 5'b11011;
   localparam logic [SEL_W-1:0] ALU_DIV    = 5'b11100;
   localparam logic [SEL_W-1:0] ALU_REM    = 5'b11101;

   typedef enum logic [2:0] {
      IMM_I = 3'd0,
      IMM_S = 3'd1,
      IMM_B = 3'd2,
      IMM_U = 3'd3,
      IMM_J = 3'd4
   } imm_sel_e;

   typedef struct packed {
      logic             valid;
      logic [SEL_W-1:0] alu_sel;
      logic [XLEN-1:0]  imm;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic [REG_W-1:0] rd;
      logic [XLEN-1:0]  pc;
      logic [2:0]       funct3;
      logic             src_imm;
      logic             src_pc;
      logic             reg_write;
      logic             mem_read;
      logic             mem_write;
      logic             branch;
      logic             jump;
      logic             illegal;
   } id_ex_t;

endpackage

// File: rtl/id_decode_stage_if.sv
// IF/ID-to-ID/EX handshake and decoded bundle; slave is the decode stage, master the surrounding pipeline.
interface id_decode_stage_if;
   import rv_pkg::*;

   logic                stall;
   logic                flush;
   logic                in_valid;
   logic [INSTR_W-1:0]  in_instr;
   logic [XLEN-1:0]     in_pc;
   logic                in_ready;
   logic                out_valid;
   logic [SEL_W-1:0]    out_alu_select;
   logic [XLEN-1:0]     out_imm;
   logic [REG_W-1:0]    out_rs1;
   logic [REG_W-1:0]    out_rs2;
   logic [REG_W-1:0]    out_rd;
   logic [XLEN-1:0]     out_pc;
   logic [2:0]          out_funct3;
   logic                out_src_imm;
   logic                out_src_pc;
   logic                out_reg_write;
   logic                out_mem_read;
   logic                out_mem_write;
   logic                out_branch;
   logic                out_jump;
   logic                out_illegal;

   modport slave (
      input  stall, flush, in_valid, in_instr, in_pc,
      output in_ready, out_valid, out_alu_select, out_imm, out_rs1, out_rs2, out_rd, out_pc,
             out_funct3, out_src_imm, out_src_pc, out_reg_write, out_mem_read, out_mem_write,
             out_branch, out_jump, out_illegal
   );

   modport master (
      output stall, flush, in_valid, in_instr, in_pc,
      input  in_ready, out_valid, out_alu_select, out_imm, out_rs1, out_rs2, out_rd, out_pc,
             out_funct3, out_src_imm, out_src_pc, out_reg_write, out_mem_read, out_mem_write,
             out_branch, out_jump, out_illegal
   );
endinterface

// File: rtl/id_decode_stage_imm_gen.sv
// Combinational immediate generator: builds the sign-extended I/S/B/U/J immediate from instr[31:7].
module imm_gen
   import rv_pkg::*;
(
   input  logic [31:7]     instr,
   input  imm_sel_e        imm_sel,
   output logic [XLEN-1:0] imm
);
   always_comb begin
      imm = '0;
      unique case (imm_sel)
         IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   imm = {instr[31:12], 12'b0};
         IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm = '0;
      endcase
   end
endmodule

// File: rtl/id_decode_stage.sv
// RV32I decode stage with a single ID/EX register bank; RV_M_EXT_EN adds MUL/MULH/MULHSU/MULHU/DIV/REM.
module id_decode_stage
   import rv_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   id_decode_stage_if.slave     bus
);
   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [XLEN-1:0] imm;
   imm_sel_e        imm_sel;
   logic            illegal;
   id_ex_t          d;
   id_ex_t          q;

   assign opcode = bus.in_instr[6:0];
   assign funct3 = bus.in_instr[14:12];
   assign funct7 = bus.in_instr[31:25];

   imm_gen u_imm_gen (
      .instr   (bus.in_instr[31:7]),
      .imm_sel (imm_sel),
      .imm     (imm)
   );

   // Decode of the current IF/ID instruction into the next ID/EX payload.
   always_comb begin
      d         = '0;
      imm_sel   = IMM_I;
      illegal   = 1'b0;
      d.alu_sel = ALU_ADD;
      d.rs1     = bus.in_instr[19:15];
      d.rs2     = bus.in_instr[24:20];
      d.rd      = bus.in_instr[11:7];
      d.pc      = bus.in_pc;
      d.funct3  = funct3;

      unique case (opcode)
         OPC_OP_IMM: begin
            d.src_imm   = 1'b1;
            d.reg_write = 1'b1;
            d.alu_sel   = SEL_W'({2'b00, funct3});
            if (funct3 == 3'b001 && funct7 != F7_ZERO) illegal = 1'b1;
            if (funct3 == 3'b101) begin
               if (funct7 == F7_ALT)       d.alu_sel = ALU_SRA;
               else if (funct7 != F7_ZERO) illegal = 1'b1;
            end
         end
         OPC_OP: begin
            d.reg_write = 1'b1;
            if (funct7 == F7_ZERO) begin
               d.alu_sel = SEL_W'({2'b00, funct3});
            end else if (funct7 == F7_ALT) begin
               if (funct3 == 3'b000)      d.alu_sel = ALU_SUB;
               else if (funct3 == 3'b101) d.alu_sel = ALU_SRA;
               else                       illegal = 1'b1;
`ifdef RV_M_EXT_EN
            end else if (funct7 == F7_MULDIV) begin
               unique case (funct3)
                  3'b000:  d.alu_sel = ALU_MUL;
                  3'b001:  d.alu_sel = ALU_MULH;
                  3'b010:  d.alu_sel = ALU_MULHSU;
                  3'b011:  d.alu_sel = ALU_MULHU;
                  3'b100:  d.alu_sel = ALU_DIV;
                  3'b110:  d.alu_sel = ALU_REM;
                  default: illegal = 1'b1;
               endcase
`endif
            end else begin
               illegal = 1'b1;
            end
         end
         OPC_LUI: begin
            imm_sel     = IMM_U;
            d.alu_sel   = ALU_FWD;
            d.src_imm   = 1'b1;
            d.reg_write = 1'b1;
         end
         OPC_AUIPC: begin
            imm_sel     = IMM_U;
            d.src_imm   = 1'b1;
            d.src_pc    = 1'b1;
            d.reg_write = 1'b1;
         end
         OPC_LOAD: begin
            d.src_imm   = 1'b1;
            d.mem_read  = 1'b1;
            d.reg_write = 1'b1;
         end
         OPC_STORE: begin
            imm_sel     = IMM_S;
            d.src_imm   = 1'b1;
            d.mem_write = 1'b1;
         end
         OPC_BRANCH: begin
            imm_sel   = IMM_B;
            d.alu_sel = ALU_SUB;
            d.branch  = 1'b1;
         end
         OPC_JAL: begin
            imm_sel     = IMM_J;
            d.src_imm   = 1'b1;
            d.src_pc    = 1'b1;
            d.jump      = 1'b1;
            d.reg_write = 1'b1;
         end
         OPC_JALR: begin
            d.src_imm   = 1'b1;
            d.jump      = 1'b1;
            d.reg_write = 1'b1;
         end
         default: illegal = 1'b1;
      endcase

      if (bus.in_instr[1:0] != 2'b11) illegal = 1'b1;

      d.imm = imm;
      if (illegal) begin
         d.alu_sel   = ALU_ADD;
         d.src_imm   = 1'b0;
         d.src_pc    = 1'b0;
         d.reg_write = 1'b0;
         d.mem_read  = 1'b0;
         d.mem_write = 1'b0;
         d.branch    = 1'b0;
         d.jump      = 1'b0;
      end
      d.illegal = illegal;
      if (d.rd == '0) d.reg_write = 1'b0;

      // A bubble carries no side effects downstream.
      d.valid = bus.in_valid;
      if (!bus.in_valid) begin
         d.reg_write = 1'b0;
         d.mem_read  = 1'b0;
         d.mem_write = 1'b0;
         d.branch    = 1'b0;
         d.jump      = 1'b0;
         d.illegal   = 1'b0;
      end
   end

   // ID/EX register: flush beats stall beats load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (bus.flush) begin
         q.valid     <= 1'b0;
         q.reg_write <= 1'b0;
         q.mem_read  <= 1'b0;
         q.mem_write <= 1'b0;
         q.branch    <= 1'b0;
         q.jump      <= 1'b0;
         q.illegal   <= 1'b0;
      end else if (!bus.stall) begin
         q <= d;
      end
   end

   assign bus.in_ready       = !bus.stall;
   assign bus.out_valid      = q.valid;
   assign bus.out_alu_select = q.alu_sel;
   assign bus.out_imm        = q.imm;
   assign bus.out_rs1        = q.rs1;
   assign bus.out_rs2        = q.rs2;
   assign bus.out_rd         = q.rd;
   assign bus.out_pc         = q.pc;
   assign bus.out_funct3     = q.funct3;
   assign bus.out_src_imm    = q.src_imm;
   assign bus.out_src_pc     = q.src_pc;
   assign bus.out_reg_write  = q.reg_write;
   assign bus.out_mem_read   = q.mem_read;
   assign bus.out_mem_write  = q.mem_write;
   assign bus.out_branch     = q.branch;
   assign bus.out_jump       = q.jump;
   assign bus.out_illegal    = q.illegal;
endmodule
